// File: rtl/bcd_timer_ctrl_pkg.sv
// Shared types and constants for the BCD countdown timer.
// Pure declarations; no clocked logic.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_timer_ctrl_if.sv
// Control/status bundle between a timer user (master) and the timer (slave).
// Level signals only; no handshake, the timer samples every clk edge.
interface bcd_timer_ctrl_if #(parameter int DIGITS = 4);
  import bcd_timer_pkg::*;

  logic                      load;
  logic                      start;
  logic                      pause;
  logic [BCD_W*DIGITS-1:0]   preset;
  logic [BCD_W*DIGITS-1:0]   count;
  logic                      busy;
  logic                      paused;
  logic                      done;

  modport master (
    output load, start, pause, preset,
    input  count, busy, paused, done
  );

  modport slave (
    input  load, start, pause, preset,
    output count, busy, paused, done
  );

endinterface

// File: rtl/bcd_timer_ctrl_digit_dn.sv
// One BCD decade with clamped load and borrow-chained decrement.
// Load wins over decrement; borrow_out is combinational so the chain resolves in one cycle.
module bcd_digit_dn
  import bcd_timer_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             i_load,
  input  logic [BCD_W-1:0] i_load_val,
  input  logic             i_dec_en,
  input  logic             i_borrow_in,
  output logic [BCD_W-1:0] o_digit,
  output logic             o_borrow_out,
  output logic             o_is_zero
);

  logic [BCD_W-1:0] r_digit;
  logic             w_zero;

  assign w_zero       = (r_digit == '0);
  assign o_is_zero    = w_zero;
  assign o_borrow_out = i_borrow_in & w_zero;
  assign o_digit      = r_digit;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_digit <= '0;
    end else if (i_load) begin
      r_digit <= bcd_clamp(i_load_val);
    end else if (i_dec_en && i_borrow_in) begin
      r_digit <= w_zero ? BCD_MAX : (r_digit - BCD_W'(1));
    end
  end

endmodule

// File: rtl/bcd_timer_ctrl.sv
// BCD countdown sequencer: prescaler + IDLE/RUN/PAUSE/DONE FSM over a decade chain.
// Outputs registered, one edge after the controlling input is sampled; no backpressure.
module bcd_timer_ctrl
  import bcd_timer_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 10
) (
  input  logic                 clk,
  input  logic                 clr,
  bcd_timer_ctrl_if.slave      tmr
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  state_t               r_state, w_state_nxt;
  logic [PW-1:0]        r_presc, w_presc_nxt;
  logic                 r_busy, r_paused, r_done;
  logic                 w_load, w_dec;

  logic [DIGITS:0]              w_borrow;
  logic [DIGITS-1:0]            w_zero;
  logic [BCD_W*DIGITS-1:0]      w_count;
  logic                         w_cnt_zero;
  logic                         w_dec_to_zero;

  // A borrow that survives the top digit means every digit is zero.
  assign w_borrow[0]   = 1'b1;
  assign w_cnt_zero    = w_borrow[DIGITS];
  assign w_dec_to_zero = (w_count[BCD_W-1:0] == BCD_W'(1)) && (&(w_zero | DIGITS'(1)));

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit_dn u_digit (
        .clk          (clk),
        .clr          (clr),
        .i_load       (w_load),
        .i_load_val   (tmr.preset[g*BCD_W +: BCD_W]),
        .i_dec_en     (w_dec),
        .i_borrow_in  (w_borrow[g]),
        .o_digit      (w_count[g*BCD_W +: BCD_W]),
        .o_borrow_out (w_borrow[g+1]),
        .o_is_zero    (w_zero[g])
      );
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    case (r_state)
      IDLE: begin
        if (tmr.load) begin
          w_load = 1'b1;
        end else if (tmr.start) begin
          if (w_cnt_zero) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = RUN;
            w_presc_nxt = PRESC_MAX;
          end
        end
      end
      RUN: begin
        if (tmr.pause) begin
          w_state_nxt = PAUSE;
        end else if (r_presc == '0) begin
          w_presc_nxt = PRESC_MAX;
          w_dec       = 1'b1;
          if (w_dec_to_zero) w_state_nxt = DONE;
        end else begin
          w_presc_nxt = r_presc - PW'(1);
        end
      end
      PAUSE: begin
        // Prescaler stays frozen so the pause costs exactly its own duration.
        if (tmr.load) begin
          w_load = 1'b1;
        end else if (tmr.start) begin
          w_state_nxt = w_cnt_zero ? DONE : RUN;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state  <= IDLE;
      r_presc  <= PRESC_MAX;
      r_busy   <= 1'b0;
      r_paused <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_presc  <= w_presc_nxt;
      r_busy   <= (w_state_nxt == RUN) || (w_state_nxt == PAUSE);
      r_paused <= (w_state_nxt == PAUSE);
      r_done   <= (w_state_nxt == DONE);
    end
  end

  assign tmr.count  = w_count;
  assign tmr.busy   = r_busy;
  assign tmr.paused = r_paused;
  assign tmr.done   = r_done;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Directed bench for bcd_timer_ctrl (DIGITS=4, TICK_DIV=4); hand-computed expectations.
module tb_bcd_timer_ctrl;
  import bcd_timer_pkg::*;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   errors = 0;
  int   checks = 0;

  bcd_timer_ctrl_if #(.DIGITS(4)) tmr ();

  bcd_timer_ctrl #(.DIGITS(4), .TICK_DIV(4)) dut (
    .clk (clk),
    .clr (clr),
    .tmr (tmr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag, input logic [15:0] cnt,
                            input logic bsy, input logic pau, input logic dn);
    chk({tag, ".count"},  32'(tmr.count),  32'(cnt));
    chk({tag, ".busy"},   32'(tmr.busy),   32'(bsy));
    chk({tag, ".paused"}, 32'(tmr.paused), 32'(pau));
    chk({tag, ".done"},   32'(tmr.done),   32'(dn));
  endtask

  initial begin
    tmr.load   = 1'b0;
    tmr.start  = 1'b0;
    tmr.pause  = 1'b0;
    tmr.preset = 16'h0000;

    // Reset state
    #2;
    chk_status("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    clr = 1'b1;
    tick();

    // load+start together in IDLE: load only
    tmr.preset = 16'h0012; tmr.load = 1'b1; tmr.start = 1'b1;
    tick();
    tmr.load = 1'b0; tmr.start = 1'b0;
    chk_status("ldst", 16'h0012, 1'b0, 1'b0, 1'b0);
    tick();
    chk_status("ldst_idle", 16'h0012, 1'b0, 1'b0, 1'b0);

    // Basic run from 0012, start sampled at edge n
    tmr.start = 1'b1;
    tick();
    tmr.start = 1'b0;
    chk_status("run_n", 16'h0012, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    chk("run_n3.count", 32'(tmr.count), 32'h0012);
    tick();
    chk("run_n4.count", 32'(tmr.count), 32'h0011);
    repeat (43) tick();
    chk_status("run_n47", 16'h0001, 1'b1, 1'b0, 1'b0);
    tick();
    chk_status("run_n48", 16'h0000, 1'b0, 1'b0, 1'b1);
    tick();
    chk_status("run_n49", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Borrow 0100 -> 0099
    tmr.preset = 16'h0100; tmr.load = 1'b1;
    tick();
    tmr.load = 1'b0; tmr.start = 1'b1;
    tick();
    tmr.start = 1'b0;
    repeat (4) tick();
    chk("borrow_0099", 32'(tmr.count), 32'h0099);

    // Pause, load 1000 while paused, resume -> 0999
    tmr.pause = 1'b1;
    tick();
    tmr.pause = 1'b0;
    chk_status("pause1", 16'h0099, 1'b1, 1'b1, 1'b0);
    tmr.preset = 16'h1000; tmr.load = 1'b1; tmr.start = 1'b1;
    tick();
    tmr.load = 1'b0; tmr.start = 1'b0;
    chk_status("pause_load", 16'h1000, 1'b1, 1'b1, 1'b0);
    tmr.start = 1'b1;
    tick();
    tmr.start = 1'b0;
    chk_status("resume", 16'h1000, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    chk("resume3.count", 32'(tmr.count), 32'h1000);
    tick();
    chk("borrow_0999", 32'(tmr.count), 32'h0999);

    // Load 0037 via PAUSE, run, then async reset mid-RUN
    tmr.pause = 1'b1;
    tick();
    tmr.pause = 1'b0; tmr.preset = 16'h0037; tmr.load = 1'b1;
    tick();
    tmr.load = 1'b0; tmr.start = 1'b1;
    tick();
    tmr.start = 1'b0;
    tick();
    chk_status("pre_rst", 16'h0037, 1'b1, 1'b0, 1'b0);
    #2 clr = 1'b0;
    #1;
    chk_status("async_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    clr = 1'b1;
    tick();
    // Load only takes effect in IDLE/PAUSE, so this confirms IDLE.
    tmr.preset = 16'h0005; tmr.load = 1'b1;
    tick();
    tmr.load = 1'b0;
    chk_status("rst_idle", 16'h0005, 1'b0, 1'b0, 1'b0);

    // Pause of 7 cycles on 0005: done shifts from n+20 to n+27
    tmr.start = 1'b1;
    tick();                                   // n
    tmr.start = 1'b0;
    tick();                                   // n+1
    tmr.pause = 1'b1;
    tick();                                   // n+2
    tmr.pause = 1'b0;
    chk_status("p7_enter", 16'h0005, 1'b1, 1'b1, 1'b0);
    repeat (5) tick();                        // n+7
    chk_status("p7_hold", 16'h0005, 1'b1, 1'b1, 1'b0);
    tmr.start = 1'b1;
    tick();                                   // n+8
    tmr.start = 1'b0;
    chk_status("p7_resume", 16'h0005, 1'b1, 1'b0, 1'b0);
    repeat (18) tick();                       // n+26
    chk_status("p7_n26", 16'h0001, 1'b1, 1'b0, 1'b0);
    tick();                                   // n+27
    chk_status("p7_n27", 16'h0000, 1'b0, 1'b0, 1'b1);
    tick();
    chk_status("p7_n28", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Clamp digits above 9
    tmr.preset = 16'h00C0; tmr.load = 1'b1;
    tick();
    chk("clamp_00C0", 32'(tmr.count), 32'h0090);
    tmr.preset = 16'hF0AC;
    tick();
    tmr.load = 1'b0;
    chk("clamp_F0AC", 32'(tmr.count), 32'h9099);

    // Zero start: done next cycle, busy never set
    tmr.preset = 16'h0000; tmr.load = 1'b1;
    tick();
    tmr.load = 1'b0; tmr.start = 1'b1;
    tick();
    tmr.start = 1'b0;
    chk_status("zero_start", 16'h0000, 1'b0, 1'b0, 1'b1);
    tick();
    chk_status("zero_after", 16'h0000, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_timer_ctrl.md
# bcd_timer_ctrl

Programmable BCD countdown timer controller built around a chain of mod-10 digit counters. Loads a multi-digit decimal preset, then decrements it once per prescaled tick under start/pause control, with borrow rippling across the decade digits. Emits a one-cycle `done` pulse on reaching zero. Sits above the decade-counter datapath as its sequencer, replacing ad-hoc clear-on-decode control with a clean synchronous FSM.

## Interface
Parameters:
- `DIGITS`, 4, number of BCD decade digits (1..8)
- `TICK_DIV`, 10, `clk` cycles per decrement tick (>=2)

Ports:
- `clk`  input  1  single clock, rising-edge
- `clr`  input  1  reset, asynchronous, active-low
- `load`  input  1  load `preset` into count (IDLE/PAUSE only)
- `start`  input  1  start from IDLE / resume from PAUSE
- `pause`  input  1  freeze countdown (RUN only)
- `preset`  input  4*DIGITS  BCD preset, digit 0 in [3:0]
- `count`  output  4*DIGITS  current BCD count
- `busy`  output  1  high in RUN and PAUSE
- `paused`  output  1  high in PAUSE
- `done`  output  1  one-cycle pulse on reaching zero

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Reset (`clr`=0, immediate, any state): state=IDLE, `count`=0, prescaler=TICK_DIV-1, `busy`=`paused`=`done`=0.
- IDLE: `load` -> `count`<=`preset`; else `start` with `count`!=0 -> RUN, prescaler<=TICK_DIV-1; `start` with `count`==0 -> DONE (no decrement).
- RUN: `pause` -> PAUSE (prescaler and count frozen, wins over a same-cycle tick); `load` and `start` ignored. Otherwise prescaler decrements; at prescaler==0 it reloads TICK_DIV-1 and count decrements by one in BCD.
- BCD decrement: digit 0 decrements; a digit at 0 becomes 9 and borrows from the next; digits above the first non-zero digit unchanged.
- When a decrement yields all-zero count -> DONE on that same edge.
- PAUSE: `load` -> `count`<=`preset`, stay PAUSE (load wins over `start`); `start` -> RUN, prescaler resumes from frozen value; if `count`==0 at resume -> DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE unconditionally; inputs ignored.
- Preset digits >9 are clamped to 9 on load.
- Priority per state: `pause` > tick (RUN); `load` > `start` (IDLE, PAUSE).

## Timing
- All outputs registered; `count`, `busy`, `paused`, `done` change only on `clk` rising edge (except async reset).
- `start` sampled at edge n (IDLE, count=P decimal): `busy`=1 from n+1; decrements at edges n+k*TICK_DIV, k=1..P; DONE entered at edge n+P*TICK_DIV; `done` high for cycle following; IDLE and `busy`=0 one edge later.
- `busy` drops on the edge entering DONE.
- `start` on zero count: `done` high in the cycle after the sampling edge; `busy` never asserts.
- Pause of m cycles extends total run time by exactly m cycles.
- Wrap-around: count never underflows past 0; no 99..9 wrap.

## Structure
- Shared package `bcd_timer_pkg`: state enum (IDLE, RUN, PAUSE, DONE), `BCD_W`=4, BCD max digit constant 9.
- Sub-module `bcd_digit_dn`: one decade digit with load, decrement enable, borrow-in, borrow-out, is-zero flag; instantiated DIGITS times in a generate chain.
- Prescaler and FSM live in the top.

## Test plan
- Reset: drive `clr`=0 mid-RUN with count 0037 -> `count`=0000, `busy`=0, `done`=0 immediately; state IDLE after release.
- Basic run, TICK_DIV=4: load 0012, start at edge n -> count 0011 at n+4, 0000 at n+48, `done` one-cycle pulse after edge n+48, `busy`=0 after n+49.
- Borrow: load 0100, run one tick -> 0099; load 1000 -> 0999.
- Pause/resume: count 0005, pause for 7 cycles mid-tick -> no decrement while paused, done arrives exactly 7 cycles later than unpaused run; load 0003 during PAUSE -> count 0003, still paused.
- Zero start: count 0000, assert start -> `done` pulse next cycle, `busy` never 1.
- Clamp/priority: preset digit 0xC on load -> digit reads 9; `load`+`start` same cycle in IDLE -> load only, stays IDLE.
